// File: rtl/bubble_chunk_scheduler.sv
// Chunk load sequencer for one bubble drive: fills a two-bank ping-pong
// buffer from the storage loader and steers the bit-output stage's reads.
module bubble_chunk_scheduler #(
    parameter int CHUNK_LOG2  = 6,
    parameter int BOOT_CYCLES = 4106,
    parameter int USER_CYCLES = 584
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic [2:0]  ACCTYPE,
    input  logic [12:0] BOUTCYCLENUM,
    input  logic [11:0] ABSPOS,
    input  logic        LOADACK,
    output logic        LOADREQ,
    output logic        LOADMODE,
    output logic [11:0] LOADPAGE,
    output logic [6:0]  LOADCHUNK,
    output logic        LOADBANK,
    output logic        READBANK,
    output logic        UNDERRUN,
    output logic        BUSY
);

    localparam int CSZ      = 1 << CHUNK_LOG2;
    localparam int BOOT_NCH = (BOOT_CYCLES + CSZ - 1) / CSZ;
    localparam int USER_NCH = (USER_CYCLES + CSZ - 1) / CSZ;

    localparam logic [6:0] BOOT_LAST = 7'(BOOT_NCH - 1);
    localparam logic [6:0] USER_LAST = 7'(USER_NCH - 1);

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        mode_q, mode_d;
    logic [11:0] page_q, page_d;
    logic [2:0]  acc_q, acc_d;
    logic        req_q, req_d;
    logic [6:0]  chunk_q, chunk_d;
    logic        bank_q, bank_d;
    logic [1:0]  valid_q, valid_d;
    logic        rbank_q, rbank_d;
    logic        urun_q, urun_d;
    logic [6:0]  prev_q, prev_d;
    logic        pend_q, pend_d;
    logic [6:0]  pchunk_q, pchunk_d;
    logic        pbank_q, pbank_d;

    logic [6:0] cur;
    logic [6:0] last;
    logic [6:0] nxt;
    logic       vcyc;
    logic       chg;
    logic       want;
    logic       acked;
    logic       abort;
    logic       issue_pend;

    // Next-state logic: page latch, fill sequence, streaming chunk turnover.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        page_d   = page_q;
        acc_d    = ACCTYPE;
        req_d    = req_q;
        chunk_d  = chunk_q;
        bank_d   = bank_q;
        valid_d  = valid_q;
        rbank_d  = rbank_q;
        urun_d   = urun_q;
        prev_d   = prev_q;
        pend_d   = pend_q;
        pchunk_d = pchunk_q;
        pbank_d  = pbank_q;

        cur   = 7'(BOUTCYCLENUM >> CHUNK_LOG2);
        vcyc  = (BOUTCYCLENUM != 13'h1FFF);
        chg   = vcyc && (cur != prev_q);
        last  = mode_q ? USER_LAST : BOOT_LAST;
        nxt   = (cur >= last) ? 7'd0 : cur + 7'd1;
        want  = !mode_q || (cur < last);
        acked = req_q & LOADACK;
        // 110<->111 switch restarts through OFF, like an abort
        abort = !ACCTYPE[1] || (ACCTYPE[2] && (ACCTYPE[0] != mode_q));
        issue_pend = 1'b0;

        if (ACCTYPE == 3'b100 && acc_q != 3'b100) begin
            page_d = ABSPOS;
        end

        if (vcyc && state_q != S_OFF) begin
            prev_d = cur;
        end

        if (state_q != S_OFF && abort) begin
            state_d = S_OFF;
            req_d   = 1'b0;
            valid_d = 2'b00;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    if (ACCTYPE[2] && ACCTYPE[1]) begin
                        state_d = S_FILL;
                        mode_d  = ACCTYPE[0];
                        urun_d  = 1'b0;
                        valid_d = 2'b00;
                        rbank_d = 1'b0;
                        prev_d  = 7'd0;
                        pend_d  = 1'b0;
                    end
                end
                S_FILL: begin
                    // chunk n goes to bank n; valid[0] tells which is next
                    if (acked) begin
                        req_d = 1'b0;
                        valid_d[bank_q] = 1'b1;
                        if (chunk_q[0]) begin
                            state_d = S_STREAM;
                        end
                    end else if (!req_q) begin
                        req_d   = 1'b1;
                        chunk_d = {6'd0, valid_q[0]};
                        bank_d  = valid_q[0];
                    end
                end
                S_STREAM: begin
                    if (acked) begin
                        req_d = 1'b0;
                        valid_d[bank_q] = 1'b1;
                    end
                    if (!req_q && pend_q) begin
                        issue_pend = 1'b1;
                        req_d   = 1'b1;
                        chunk_d = pchunk_q;
                        bank_d  = pbank_q;
                        pend_d  = 1'b0;
                    end
                    if (chg) begin
                        rbank_d = ~rbank_q;
                        if (!valid_d[~rbank_q]) begin
                            urun_d = 1'b1;
                        end
                        valid_d[rbank_q] = 1'b0;
                        if (want) begin
                            if (req_q || issue_pend) begin
                                if (pend_q && !issue_pend) begin
                                    urun_d = 1'b1;
                                end
                                pend_d   = 1'b1;
                                pchunk_d = nxt;
                                pbank_d  = rbank_q;
                            end else begin
                                req_d   = 1'b1;
                                chunk_d = nxt;
                                bank_d  = rbank_q;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_OFF;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_OFF;
            mode_q   <= 1'b0;
            page_q   <= 12'd0;
            acc_q    <= 3'b000;
            req_q    <= 1'b0;
            chunk_q  <= 7'd0;
            bank_q   <= 1'b0;
            valid_q  <= 2'b00;
            rbank_q  <= 1'b0;
            urun_q   <= 1'b0;
            prev_q   <= 7'd0;
            pend_q   <= 1'b0;
            pchunk_q <= 7'd0;
            pbank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            page_q   <= page_d;
            acc_q    <= acc_d;
            req_q    <= req_d;
            chunk_q  <= chunk_d;
            bank_q   <= bank_d;
            valid_q  <= valid_d;
            rbank_q  <= rbank_d;
            urun_q   <= urun_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            pchunk_q <= pchunk_d;
            pbank_q  <= pbank_d;
        end
    end

    assign LOADREQ   = req_q;
    assign LOADMODE  = mode_q;
    assign LOADPAGE  = page_q;
    assign LOADCHUNK = chunk_q;
    assign LOADBANK  = bank_q;
    assign READBANK  = rbank_q;
    assign UNDERRUN  = urun_q;
    assign BUSY      = (state_q != S_OFF);

endmodule

// File: tb/tb_bubble_chunk_scheduler.sv
// Bench for bubble_chunk_scheduler: directed handshake/abort/reset steps
// plus randomized user and boot streams against a chunk-sequence model.
module tb_bubble_chunk_scheduler;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [2:0]  ACCTYPE = 3'b000;
    logic [12:0] BOUTCYCLENUM = 13'h1FFF;
    logic [11:0] ABSPOS = 12'd0;
    logic        LOADACK;
    logic        LOADREQ;
    logic        LOADMODE;
    logic [11:0] LOADPAGE;
    logic [6:0]  LOADCHUNK;
    logic        LOADBANK;
    logic        READBANK;
    logic        UNDERRUN;
    logic        BUSY;

    logic man_ack = 1'b0;
    logic aack = 1'b0;
    logic auto_on = 1'b0;
    assign LOADACK = man_ack | aack;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]  c;
        logic        b;
        logic        m;
        logic [11:0] p;
    } req_t;
    req_t seen_q[$];

    bubble_chunk_scheduler dut (
        .MCLK(MCLK), .nRESET(nRESET), .ACCTYPE(ACCTYPE),
        .BOUTCYCLENUM(BOUTCYCLENUM), .ABSPOS(ABSPOS), .LOADACK(LOADACK),
        .LOADREQ(LOADREQ), .LOADMODE(LOADMODE), .LOADPAGE(LOADPAGE),
        .LOADCHUNK(LOADCHUNK), .LOADBANK(LOADBANK), .READBANK(READBANK),
        .UNDERRUN(UNDERRUN), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    // Loader model: record each request, hold it a random time, then ack.
    always begin
        @(posedge MCLK);
        #1;
        if (auto_on && LOADREQ) begin
            req_t r;
            int d;
            logic live;
            r = '{c: LOADCHUNK, b: LOADBANK, m: LOADMODE, p: LOADPAGE};
            seen_q.push_back(r);
            d = $urandom_range(1, 8);
            live = 1'b1;
            for (int k = 0; k < d && live; k++) begin
                @(posedge MCLK);
                #1;
                if (!LOADREQ) begin
                    live = 1'b0;
                end else begin
                    chk("req_stable_chunk", 32'(LOADCHUNK), 32'(r.c));
                    chk("req_stable_bank", 32'(LOADBANK), 32'(r.b));
                    chk("req_stable_page", 32'(LOADPAGE), 32'(r.p));
                end
            end
            if (live) begin
                aack = 1'b1;
                @(posedge MCLK);
                #1;
                aack = 1'b0;
            end
        end
    end

    task automatic pulse_ack();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
    endtask

    task automatic wait_fill();
        int t;
        t = 0;
        while (!(seen_q.size() >= 2 && !LOADREQ) && t < 200) begin
            tick();
            t++;
        end
        chk("fill_timeout", 32'(t < 200), 32'd1);
    endtask

    // Model: the n-th chunk streamed is chunk n mod NCH, held in bank n mod 2;
    // entering position n requests position n+1 (user stops at the last chunk).
    task automatic stream(input logic boot, input int total,
                          input logic [11:0] page);
        int ncyc;
        int nch;
        int n;
        int pc;
        int c;
        int nreq;
        req_t r;
        ncyc = boot ? 4106 : 584;
        nch  = boot ? 65 : 10;
        n = 0;
        pc = -1;
        for (int i = 0; i < total; i++) begin
            BOUTCYCLENUM = 13'(i % ncyc);
            c = (i % ncyc) / 64;
            tick();
            if (pc >= 0 && c != pc) n++;
            if (c != pc) chk("readbank", 32'(READBANK), 32'(n % 2));
            if ($urandom_range(0, 3) == 0) tick();
            pc = c;
        end
        BOUTCYCLENUM = 13'h1FFF;
        repeat (20) tick();
        nreq = boot ? n + 2 : ((n + 2 < 10) ? n + 2 : 10);
        chk("req_count", 32'(seen_q.size()), 32'(nreq));
        for (int k = 0; k < nreq && k < seen_q.size(); k++) begin
            r = seen_q[k];
            chk("req_chunk", 32'(r.c), 32'(k % nch));
            chk("req_bank", 32'(r.b), 32'(k % 2));
            chk("req_mode", 32'(r.m), 32'(!boot));
            chk("req_page", 32'(r.p), 32'(page));
        end
        chk("no_underrun", 32'(UNDERRUN), 32'd0);
    endtask

    initial begin
        logic [11:0] page_exp;

        #12;
        chk("rst_req", 32'(LOADREQ), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_page", 32'(LOADPAGE), 32'd0);
        chk("rst_rbank", 32'(READBANK), 32'd0);
        chk("rst_urun", 32'(UNDERRUN), 32'd0);
        nRESET = 1'b1;
        tick();

        // page latch and manual fill
        ACCTYPE = 3'b100; ABSPOS = 12'd1234;
        tick();
        ABSPOS = 12'd77;
        tick();
        ACCTYPE = 3'b111;
        tick();
        chk("fill_busy", 32'(BUSY), 32'd1);
        chk("fill_req_lat", 32'(LOADREQ), 32'd0);
        chk("page_latch", 32'(LOADPAGE), 32'd1234);
        tick();
        chk("fill0_req", 32'(LOADREQ), 32'd1);
        chk("fill0_chunk", 32'(LOADCHUNK), 32'd0);
        chk("fill0_bank", 32'(LOADBANK), 32'd0);
        chk("fill_mode", 32'(LOADMODE), 32'd1);
        repeat (4) tick();
        pulse_ack();
        chk("fill0_drop", 32'(LOADREQ), 32'd0);
        tick();
        chk("fill1_req", 32'(LOADREQ), 32'd1);
        chk("fill1_chunk", 32'(LOADCHUNK), 32'd1);
        chk("fill1_bank", 32'(LOADBANK), 32'd1);
        repeat (4) tick();
        pulse_ack();

        // underrun with ack withheld
        BOUTCYCLENUM = 13'd63;
        tick();
        chk("u63_req", 32'(LOADREQ), 32'd0);
        chk("u63_rbank", 32'(READBANK), 32'd0);
        BOUTCYCLENUM = 13'd64;
        tick();
        chk("u64_req", 32'(LOADREQ), 32'd1);
        chk("u64_chunk", 32'(LOADCHUNK), 32'd2);
        chk("u64_bank", 32'(LOADBANK), 32'd0);
        chk("u64_rbank", 32'(READBANK), 32'd1);
        chk("u64_urun", 32'(UNDERRUN), 32'd0);
        BOUTCYCLENUM = 13'd128;
        tick();
        chk("u128_urun", 32'(UNDERRUN), 32'd1);
        chk("u128_rbank", 32'(READBANK), 32'd0);
        chk("u128_chunk", 32'(LOADCHUNK), 32'd2);
        pulse_ack();
        chk("pend_gap", 32'(LOADREQ), 32'd0);
        tick();
        chk("pend_req", 32'(LOADREQ), 32'd1);
        chk("pend_chunk", 32'(LOADCHUNK), 32'd3);
        chk("pend_bank", 32'(LOADBANK), 32'd1);

        // abort with request outstanding, late ack ignored
        ACCTYPE = 3'b100; ABSPOS = 12'd500;
        tick();
        chk("abort_req", 32'(LOADREQ), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_page", 32'(LOADPAGE), 32'd500);
        pulse_ack();
        tick();
        chk("late_ack_req", 32'(LOADREQ), 32'd0);
        chk("late_ack_busy", 32'(BUSY), 32'd0);

        // restart clears underrun; 111->110 goes through OFF
        BOUTCYCLENUM = 13'h1FFF;
        ACCTYPE = 3'b111;
        tick();
        chk("restart_busy", 32'(BUSY), 32'd1);
        chk("restart_urun", 32'(UNDERRUN), 32'd0);
        ACCTYPE = 3'b110;
        tick();
        chk("switch_off", 32'(BUSY), 32'd0);
        tick();
        chk("switch_fill", 32'(BUSY), 32'd1);
        chk("switch_mode", 32'(LOADMODE), 32'd0);
        tick();
        chk("switch_req", 32'(LOADREQ), 32'd1);

        // asynchronous reset mid-fill
        nRESET = 1'b0;
        #1;
        chk("arst_req", 32'(LOADREQ), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_page", 32'(LOADPAGE), 32'd0);
        chk("arst_chunk", 32'(LOADCHUNK), 32'd0);
        ACCTYPE = 3'b000;
        tick();
        nRESET = 1'b1;
        tick();
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_req", 32'(LOADREQ), 32'd0);

        // randomized user page stream
        page_exp = 12'($urandom_range(0, 2052));
        ACCTYPE = 3'b100; ABSPOS = page_exp;
        tick();
        ABSPOS = 12'($urandom_range(0, 2052));
        tick();
        seen_q.delete();
        auto_on = 1'b1;
        ACCTYPE = 3'b111;
        wait_fill();
        stream(1'b0, 584, page_exp);

        // randomized boot loop with wrap
        ACCTYPE = 3'b000;
        tick();
        seen_q.delete();
        ACCTYPE = 3'b110;
        wait_fill();
        stream(1'b1, 4106 + 200, page_exp);

        auto_on = 1'b0;
        ACCTYPE = 3'b000;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
